// File: rtl/qm_muldiv_pkg.sv
// Shared operation codes, FSM encoding and op-class helpers for the
// iterative multiply/divide unit.
package qm_muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        QM_MD_IDLE = 2'd0,
        QM_MD_RUN  = 2'd1,
        QM_MD_FIX  = 2'd2
    } md_state_t;

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/qm_muldiv_signfix.sv
// Sign conditioning: operand magnitudes at start, and result negation
// (64-bit product or separate quotient/remainder) in the FIX cycle.
module qm_muldiv_signfix
    import qm_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_op,
    output logic [WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0] b_mag,
    output logic             a_neg,
    output logic             b_neg,
    input  logic [WIDTH-1:0] hi_raw,
    input  logic [WIDTH-1:0] lo_raw,
    input  logic             is_mul,
    input  logic             neg_q,
    input  logic             neg_r,
    output logic [WIDTH-1:0] hi_fix,
    output logic [WIDTH-1:0] lo_fix
);

    logic signed [WIDTH-1:0]   a_s;
    logic signed [WIDTH-1:0]   b_s;
    logic signed [WIDTH-1:0]   hi_s;
    logic signed [WIDTH-1:0]   lo_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic signed [2*WIDTH-1:0] prod_neg;
    logic signed [WIDTH-1:0]   hi_neg;
    logic signed [WIDTH-1:0]   lo_neg;

    assign a_s = a;
    assign b_s = b;

    // The most negative value negates to itself, which is exactly the
    // unsigned magnitude the datapath needs.
    assign a_neg = signed_op & a[WIDTH-1];
    assign b_neg = signed_op & b[WIDTH-1];
    assign a_mag = a_neg ? -a_s : a_s;
    assign b_mag = b_neg ? -b_s : b_s;

    assign hi_s     = hi_raw;
    assign lo_s     = lo_raw;
    assign prod_s   = {hi_raw, lo_raw};
    assign prod_neg = -prod_s;
    assign hi_neg   = -hi_s;
    assign lo_neg   = -lo_s;

    always_comb begin
        hi_fix = hi_raw;
        lo_fix = lo_raw;
        if (is_mul) begin
            if (neg_q) begin
                hi_fix = prod_neg[2*WIDTH-1:WIDTH];
                lo_fix = prod_neg[WIDTH-1:0];
            end
        end else begin
            if (neg_q) lo_fix = lo_neg;
            if (neg_r) hi_fix = hi_neg;
        end
    end

endmodule

// File: rtl/qm_muldiv.sv
// Radix-2 iterative multiply/divide unit with architectural HI/LO registers;
// one 32-step sequencer shared by multiply (shift-add) and divide (restoring).
module qm_muldiv
    import qm_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             i_Start,
    input  logic [2:0]       i_Op,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [WIDTH-1:0] o_HI,
    output logic [WIDTH-1:0] o_LO
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_t        state;
    md_state_t        state_nxt;
    logic [CNT_W-1:0] iter_cnt;
    logic             done;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] a_orig;
    logic             is_mul;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;

    logic             start_iter;
    logic             start_idle;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] hi_fix;
    logic [WIDTH-1:0] lo_fix;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign start_idle = (state == QM_MD_IDLE) && i_Start;
    assign start_iter = start_idle && is_iter_op(i_Op);

    qm_muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .a         (i_A),
        .b         (i_B),
        .signed_op (is_signed_op(i_Op)),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .hi_raw    (acc_hi),
        .lo_raw    (acc_lo),
        .is_mul    (is_mul),
        .neg_q     (neg_q),
        .neg_r     (neg_r),
        .hi_fix    (hi_fix),
        .lo_fix    (lo_fix)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= QM_MD_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            QM_MD_IDLE: if (start_iter) state_nxt = QM_MD_RUN;
            QM_MD_RUN:  if (iter_cnt == CNT_W'(WIDTH - 1)) state_nxt = QM_MD_FIX;
            QM_MD_FIX:  state_nxt = QM_MD_IDLE;
            default:    state_nxt = QM_MD_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            iter_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == QM_MD_FIX);
            if (start_iter)              iter_cnt <= '0;
            else if (state == QM_MD_RUN) iter_cnt <= iter_cnt + 1'b1;
        end
    end

    // One radix-2 step: multiply keeps {acc_hi, multiplier} shifting right,
    // divide keeps {remainder, quotient} shifting left.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    always_ff @(posedge sys_clk) begin
        if (start_iter) begin
            is_mul   <= is_mul_op(i_Op);
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= !is_mul_op(i_Op) && (i_B == '0);
            a_orig   <= i_A;
            acc_hi   <= '0;
            acc_lo   <= is_mul_op(i_Op) ? b_mag : a_mag;
            opnd     <= is_mul_op(i_Op) ? a_mag : b_mag;
        end else if (state == QM_MD_RUN) begin
            if (is_mul) begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end else begin
                acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end
        end
    end

    // Divide by zero bypasses sign correction: HI returns the raw dividend.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state == QM_MD_FIX) begin
            hi_reg <= div_zero ? a_orig : hi_fix;
            lo_reg <= div_zero ? '1 : lo_fix;
        end else if (start_idle && (i_Op == MD_MTHI)) begin
            hi_reg <= i_A;
        end else if (start_idle && (i_Op == MD_MTLO)) begin
            lo_reg <= i_A;
        end
    end

    assign o_Busy = (state != QM_MD_IDLE);
    assign o_Done = done;
    assign o_HI   = hi_reg;
    assign o_LO   = lo_reg;

endmodule

// File: tb/tb_qm_muldiv.sv
// Self-checking bench for qm_muldiv: directed corner cases plus randomized
// mul/div operations compared against an arithmetic reference model.
module tb_qm_muldiv;
    import qm_muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    qm_muldiv #(.WIDTH(32)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .i_Start (start),
        .i_Op    (op),
        .i_A     (a),
        .i_B     (b),
        .o_Busy  (busy),
        .o_Done  (done),
        .o_HI    (hi),
        .o_LO    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {HI, LO} from MIPS arithmetic semantics.
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      p;
        logic [63:0] pu;
        int          sx;
        int          sy;
        int          q;
        int          r;
        case (o)
            MD_MULT: begin
                p = longint'(signed'(x)) * longint'(signed'(y));
                return p;
            end
            MD_MULTU: begin
                pu = {32'd0, x} * {32'd0, y};
                return pu;
            end
            MD_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sx = x;
                sy = y;
                q  = sx / sy;
                r  = sx % sy;
                return {r, q};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Caller is positioned at a falling edge; start is sampled at the next rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts busy cycles and checks the result at the falling edge where o_Done shows.
    task automatic wait_result(input string tag, input logic [63:0] exp, input bit scramble, input int glitch_at);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 100) begin
            cnt++;
            if (start) start = 1'b0;
            if (scramble) begin
                a = $urandom;
                b = $urandom;
            end
            if (cnt == glitch_at) begin
                op    = MD_MULTU;
                a     = 32'd2;
                b     = 32'd3;
                start = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_val({tag, "_busy_cycles"}, 64'(cnt), 64'd33);
        check_val({tag, "_done"}, {63'd0, done}, 64'd1);
        check_val({tag, "_hilo"}, {hi, lo}, exp);
    endtask

    initial begin
        logic [63:0] exp;
        logic [63:0] saved;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          pulses;

        rst   = 1'b1;
        start = 1'b0;
        op    = MD_MULT;
        a     = '0;
        b     = '0;
        #2;
        check_val("reset_outputs", {30'd0, busy, done, hi, lo}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("multu_max", 64'hFFFF_FFFE_0000_0001, 1'b0, 0);
        @(negedge clk);
        check_val("done_one_cycle", {63'd0, done}, 64'd0);

        issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_result("mult_neg", ref_md(MD_MULT, 32'hFFFF_FFFD, 32'd7), 1'b0, 0);

        @(negedge clk);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_neg", 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0);

        @(negedge clk);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_ovf", 64'h0000_0000_8000_0000, 1'b0, 0);

        @(negedge clk);
        issue(MD_DIVU, 32'd100, 32'd0);
        wait_result("divu_zero", 64'h0000_0064_FFFF_FFFF, 1'b0, 0);

        @(negedge clk);
        issue(MD_DIV, 32'hFFFF_FF00, 32'd0);
        wait_result("div_zero_signed", 64'hFFFF_FF00_FFFF_FFFF, 1'b0, 0);

        // MTHI / MTLO take effect at the start edge without going busy.
        @(negedge clk);
        saved = {hi, lo};
        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        check_val("mthi_hilo", {hi, lo}, {32'h1234_5678, saved[31:0]});
        @(negedge clk);
        check_val("mthi_no_busy", {62'd0, busy, done}, 64'd0);
        issue(MD_MTLO, 32'h0BAD_F00D, 32'd0);
        check_val("mtlo_hilo", {hi, lo}, {32'h1234_5678, 32'h0BAD_F00D});
        @(negedge clk);
        check_val("mtlo_no_busy", {62'd0, busy, done}, 64'd0);

        issue(3'd6, 32'hDEAD_BEEF, 32'h1);
        @(negedge clk);
        check_val("unknown_op", {30'd0, busy, done, hi, lo}, {32'h1234_5678, 32'h0BAD_F00D});

        // Start during busy is ignored; a start in the done cycle is accepted.
        issue(MD_DIVU, 32'd50, 32'd7);
        wait_result("divu_glitch", 64'h0000_0001_0000_0007, 1'b0, 5);
        issue(MD_MULTU, 32'd2, 32'd3);
        wait_result("back_to_back", 64'h0000_0000_0000_0006, 1'b0, 0);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'($urandom_range(1, 15));
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            exp = ref_md(rop, ra, rb);
            issue(rop, ra, rb);
            wait_result($sformatf("rand%0d_op%0d", i, rop), exp, 1'b1, 0);
            @(negedge clk);
        end

        // Asynchronous reset mid-operation.
        issue(MD_MULTU, 32'd9, 32'd9);
        for (int i = 0; i < 10; i++) @(negedge clk);
        check_val("pre_reset_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check_val("async_reset", {31'd0, busy, hi, lo}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check_val("no_done_after_reset", 64'(pulses), 64'd0);
        check_val("hilo_after_reset", {hi, lo}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
